// File: rtl/parser_type_lookup.sv
// ============================================================================
// parser_type_lookup : per-layer type match stage (extract -> match, 2 cycles)
// Rev 1.0
// ============================================================================
`default_nettype none

package parser_type_lookup_pkg;
  localparam int TYPE_NUM          = 2;
  localparam int TAG_WIDTH         = 8;
  localparam int HEAD_WIDTH        = 256;
  localparam int TYPE_OFFSET_WIDTH = 5;
  localparam int KEY_NUM           = 4;
  localparam int KEY_IDX_WIDTH     = $clog2(KEY_NUM);
  localparam int KEY_OFFSET_WIDTH  = 6;
  localparam int HEAD_SHIFT_WIDTH  = 6;
  localparam int META_SHIFT_WIDTH  = 5;
  localparam int META_CANDI_NUM    = 32;

  localparam logic [1:0] LAYER_0 = 2'd0;
  localparam logic [1:0] LAYER_1 = 2'd1;
  localparam logic [1:0] LAYER_2 = 2'd2;
  localparam logic [1:0] LAYER_3 = 2'd3;

  typedef struct packed {
    logic [HEAD_WIDTH+TAG_WIDTH-1:0]                  head;
    logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]       type_offset;
    logic [META_SHIFT_WIDTH-1:0]                      total_metaShift;
  } layer_info_t;

  typedef struct packed {
    logic                                             typeRule_valid;
    logic [TYPE_NUM-1:0][7:0]                         typeRule_typeData;
    logic [TYPE_NUM-1:0][7:0]                         typeRule_typeMask;
    logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]       typeRule_typeOffset;
    logic [KEY_NUM-1:0]                               typeRule_keyOffset_v;
    logic [KEY_NUM-1:0][KEY_OFFSET_WIDTH-1:0]         typeRule_keyOffset;
    logic [KEY_NUM-1:0][KEY_OFFSET_WIDTH-1:0]         typeRule_keyReplaceOffset;
    logic [HEAD_SHIFT_WIDTH-1:0]                      typeRule_headShift;
    logic [META_SHIFT_WIDTH-1:0]                      typeRule_metaShift;
  } type_rule_t;

  typedef struct packed {
    logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]       typeOffset;
    logic [KEY_NUM-1:0]                               keyOffset_v;
    logic [KEY_NUM-1:0][KEY_OFFSET_WIDTH-1:0]         keyOffset;
    logic [HEAD_SHIFT_WIDTH-1:0]                      headShift;
    logic [META_SHIFT_WIDTH-1:0]                      metaShift;
    logic [KEY_NUM-1:0][KEY_OFFSET_WIDTH-1:0]         k_replaceOffset;
    logic [META_SHIFT_WIDTH-1:0]                      total_metaShift;
    logic                                             metaShift_carry;
    logic [META_CANDI_NUM-1:0]                        m_replaceOffset_v;
    logic [META_CANDI_NUM-1:0][KEY_IDX_WIDTH-1:0]     m_replaceOffset;
    logic [META_CANDI_NUM-1:0]                        m_replaceOffset_carry;
  } lookup_rst_t;
endpackage

module parser_type_lookup
  import parser_type_lookup_pkg::*;
#(
  parameter int         RULE_NUM = 8,
  parameter logic [1:0] LAYER_ID = LAYER_0
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_info_valid,
  output logic                        o_info_ready,
  input  layer_info_t                 i_info,
  output logic                        o_info_valid,
  input  logic                        i_info_ready,
  output layer_info_t                 o_info,
  output lookup_rst_t                 o_lookup,
  output logic                        o_hit,
  output logic [$clog2(RULE_NUM)-1:0] o_hit_idx,
  output logic [1:0]                  o_layer_id,
  input  logic                        i_rule_wren,
  input  logic                        i_rule_rden,
  input  logic [$clog2(RULE_NUM)-1:0] i_rule_addr,
  input  type_rule_t                  i_rule_wdata,
  output logic                        o_rule_rvalid,
  output type_rule_t                  o_rule_rdata
);
  localparam int IDX_W = $clog2(RULE_NUM);
  localparam int HW    = HEAD_WIDTH + TAG_WIDTH;

  type_rule_t                  r_rules [RULE_NUM];
  logic                        r_s1_valid;
  layer_info_t                 r_s1_info;
  logic [TYPE_NUM-1:0][7:0]    r_s1_type;
  logic                        r_s2_valid;

  logic                        w_en;
  logic [HW-1:0]               w_head_sh;
  logic [TYPE_NUM-1:0][7:0]    w_type;
  logic [RULE_NUM-1:0]         w_match;
  logic                        w_hit;
  logic [IDX_W-1:0]            w_hit_idx;
  type_rule_t                  w_rule;
  lookup_rst_t                 w_lookup;
  logic [META_SHIFT_WIDTH:0]   w_slot_sum;

  assign w_en         = ~r_s2_valid | i_info_ready;
  assign o_info_ready = w_en;
  assign o_info_valid = r_s2_valid;
  assign o_layer_id   = LAYER_ID;

  // Shifting the wanted byte to the top avoids a wide variable part-select.
  always_comb begin
    w_head_sh = '0;
    w_type    = '0;
    for (int k = 0; k < TYPE_NUM; k++) begin
      w_head_sh = i_info.head << {i_info.type_offset[k], 3'b000};
      w_type[k] = w_head_sh[HW-1 -: 8];
    end
  end

  always_comb begin
    w_match = '0;
    for (int r = 0; r < RULE_NUM; r++) begin
      w_match[r] = r_rules[r].typeRule_valid;
      for (int k = 0; k < TYPE_NUM; k++) begin
        if (((r_s1_type[k] ^ r_rules[r].typeRule_typeData[k]) &
             r_rules[r].typeRule_typeMask[k]) != 8'h00)
          w_match[r] = 1'b0;
      end
    end
  end

  // Descending scan so the lowest matching index is the last one written.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    w_rule    = '0;
    for (int r = RULE_NUM - 1; r >= 0; r--) begin
      if (w_match[r]) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(r);
        w_rule    = r_rules[r];
      end
    end
  end

  // META_CANDI_NUM equals 2**META_SHIFT_WIDTH, so the slot is the low bits of the sum.
  always_comb begin
    w_lookup                 = '0;
    w_slot_sum               = '0;
    w_lookup.total_metaShift = r_s1_info.total_metaShift;
    if (w_hit) begin
      w_lookup.typeOffset      = w_rule.typeRule_typeOffset;
      w_lookup.keyOffset_v     = w_rule.typeRule_keyOffset_v;
      w_lookup.keyOffset       = w_rule.typeRule_keyOffset;
      w_lookup.headShift       = w_rule.typeRule_headShift;
      w_lookup.metaShift       = w_rule.typeRule_metaShift;
      w_lookup.k_replaceOffset = w_rule.typeRule_keyReplaceOffset;
      {w_lookup.metaShift_carry, w_lookup.total_metaShift} =
          {1'b0, r_s1_info.total_metaShift} + {1'b0, w_rule.typeRule_metaShift};
      for (int i = 0; i < KEY_NUM; i++) begin
        if (w_rule.typeRule_keyOffset_v[i]) begin
          w_slot_sum = {1'b0, r_s1_info.total_metaShift} + (META_SHIFT_WIDTH+1)'(i);
          w_lookup.m_replaceOffset_v[w_slot_sum[META_SHIFT_WIDTH-1:0]]     = 1'b1;
          w_lookup.m_replaceOffset[w_slot_sum[META_SHIFT_WIDTH-1:0]]       = KEY_IDX_WIDTH'(i);
          w_lookup.m_replaceOffset_carry[w_slot_sum[META_SHIFT_WIDTH-1:0]] = w_slot_sum[META_SHIFT_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_info  <= '0;
      r_s1_type  <= '0;
      r_s2_valid <= 1'b0;
      o_info     <= '0;
      o_lookup   <= '0;
      o_hit      <= 1'b0;
      o_hit_idx  <= '0;
    end else if (w_en) begin
      r_s1_valid <= i_info_valid;
      r_s1_info  <= i_info;
      r_s1_type  <= w_type;
      r_s2_valid <= r_s1_valid;
      o_info     <= r_s1_info;
      o_lookup   <= w_lookup;
      o_hit      <= w_hit;
      o_hit_idx  <= w_hit_idx;
    end
  end

  // Rule table and its config port run independently of the pipeline stall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < RULE_NUM; r++) r_rules[r] <= '0;
      o_rule_rvalid <= 1'b0;
      o_rule_rdata  <= '0;
    end else begin
      if (i_rule_wren) r_rules[i_rule_addr] <= i_rule_wdata;
      o_rule_rvalid <= i_rule_rden;
      if (i_rule_rden) o_rule_rdata <= r_rules[i_rule_addr];
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_parser_type_lookup.sv
// ============================================================================
// tb_parser_type_lookup : directed self-checking bench for parser_type_lookup
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_parser_type_lookup;
  import parser_type_lookup_pkg::*;

  localparam int RULE_NUM = 8;
  localparam int IW       = $clog2(RULE_NUM);
  localparam int HW       = HEAD_WIDTH + TAG_WIDTH;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  layer_info_t in_info = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  layer_info_t out_info;
  lookup_rst_t out_lookup;
  logic        hit;
  logic [IW-1:0] hit_idx;
  logic [1:0]  layer_id;
  logic        wren = 1'b0;
  logic        rden = 1'b0;
  logic [IW-1:0] addr = '0;
  type_rule_t  wdata = '0;
  logic        rvalid;
  type_rule_t  rdata;

  int total = 0;
  int bad   = 0;

  type_rule_t rule1, rule2, rule3, rule5;

  parser_type_lookup #(.RULE_NUM(RULE_NUM), .LAYER_ID(LAYER_0)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_info_valid (in_valid),
    .o_info_ready (in_ready),
    .i_info       (in_info),
    .o_info_valid (out_valid),
    .i_info_ready (out_ready),
    .o_info       (out_info),
    .o_lookup     (out_lookup),
    .o_hit        (hit),
    .o_hit_idx    (hit_idx),
    .o_layer_id   (layer_id),
    .i_rule_wren  (wren),
    .i_rule_rden  (rden),
    .i_rule_addr  (addr),
    .i_rule_wdata (wdata),
    .o_rule_rvalid(rvalid),
    .o_rule_rdata (rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic layer_info_t mk_beat(input int off0, input int off1,
                                          input logic [7:0] t0, input logic [7:0] t1,
                                          input logic [4:0] tms, input logic [7:0] seed);
    layer_info_t b;
    logic [7:0]  v;
    b = '0;
    for (int k = 0; k < HW / 8; k++) begin
      v = seed + 8'(k);
      if (k == off0) v = t0;
      else if (k == off1) v = t1;
      b.head = {b.head[HW-9:0], v};
    end
    b.type_offset[0]   = 5'(off0);
    b.type_offset[1]   = 5'(off1);
    b.total_metaShift  = tms;
    return b;
  endfunction

  task automatic write_rule(input logic [IW-1:0] a, input type_rule_t r);
    wren = 1'b1; addr = a; wdata = r;
    tick();
    wren = 1'b0;
  endtask

  task automatic send_one(input layer_info_t b);
    in_valid = 1'b1; in_info = b;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(); tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_lookup !== '0) begin bad++; $display("FAIL reset_lookup got=%h exp=0", out_lookup); end
    total++; if (out_info !== '0 || hit !== 1'b0 || hit_idx !== '0) begin bad++; $display("FAIL reset_info_hit got info=%h hit=%b idx=%0d exp 0", out_info, hit, hit_idx); end
    total++; if (rvalid !== 1'b0 || rdata !== '0) begin bad++; $display("FAIL reset_rport got rvalid=%b rdata=%h exp 0", rvalid, rdata); end
    rst_n = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1 || layer_id !== 2'd0) begin bad++; $display("FAIL reset_ready got ready=%b id=%0d exp 1/0", in_ready, layer_id); end
    rden = 1'b1; addr = 3'd0;
    tick();
    rden = 1'b0;
    total++; if (rvalid !== 1'b1 || rdata !== '0) begin bad++; $display("FAIL reset_rule0 got rvalid=%b rdata=%h exp 1/0", rvalid, rdata); end
  endtask

  task automatic test_miss;
    layer_info_t b;
    lookup_rst_t e;
    b = mk_beat(3, 4, 8'h12, 8'h34, 5'd7, 8'h40);
    e = '0; e.total_metaShift = 5'd7;
    in_valid = 1'b1; in_info = b;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL miss_early got=%b exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL miss_latency got=%b exp=1", out_valid); end
    total++; if (hit !== 1'b0 || hit_idx !== '0) begin bad++; $display("FAIL miss_hit got hit=%b idx=%0d exp 0/0", hit, hit_idx); end
    total++; if (out_lookup !== e) begin bad++; $display("FAIL miss_lookup got=%h exp=%h", out_lookup, e); end
    total++; if (out_info !== b) begin bad++; $display("FAIL miss_info got=%h exp=%h", out_info, b); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL miss_single got=%b exp=0", out_valid); end
  endtask

  task automatic test_hit_meta;
    layer_info_t b;
    lookup_rst_t e;
    write_rule(3'd1, rule1);
    b = mk_beat(12, 13, 8'h08, 8'h00, 5'd30, 8'h50);
    e = '0;
    e.typeOffset[0] = 5'd20; e.typeOffset[1] = 5'd21;
    e.keyOffset_v = 4'hF;
    e.keyOffset[0] = 6'd1;  e.keyOffset[1] = 6'd2;  e.keyOffset[2] = 6'd3;  e.keyOffset[3] = 6'd4;
    e.k_replaceOffset[0] = 6'd10; e.k_replaceOffset[1] = 6'd11;
    e.k_replaceOffset[2] = 6'd12; e.k_replaceOffset[3] = 6'd13;
    e.headShift = 6'd7; e.metaShift = 5'd3;
    e.total_metaShift = 5'd1; e.metaShift_carry = 1'b1;
    e.m_replaceOffset_v = 32'hC000_0003;
    e.m_replaceOffset[30] = 2'd0; e.m_replaceOffset[31] = 2'd1;
    e.m_replaceOffset[0]  = 2'd2; e.m_replaceOffset[1]  = 2'd3;
    e.m_replaceOffset_carry = 32'h0000_0003;
    send_one(b);
    total++; if (out_valid !== 1'b1 || hit !== 1'b1 || hit_idx !== 3'd1) begin bad++; $display("FAIL hit1_idx got v=%b hit=%b idx=%0d exp 1/1/1", out_valid, hit, hit_idx); end
    total++; if (out_lookup.headShift !== 6'd7 || out_lookup.total_metaShift !== 5'd1 || out_lookup.metaShift_carry !== 1'b1) begin bad++; $display("FAIL hit1_shift got hs=%0d tms=%0d c=%b exp 7/1/1", out_lookup.headShift, out_lookup.total_metaShift, out_lookup.metaShift_carry); end
    total++; if (out_lookup.m_replaceOffset_v !== 32'hC000_0003 || out_lookup.m_replaceOffset_carry !== 32'h0000_0003) begin bad++; $display("FAIL hit1_mslots got v=%h c=%h exp c0000003/00000003", out_lookup.m_replaceOffset_v, out_lookup.m_replaceOffset_carry); end
    total++; if (out_lookup !== e) begin bad++; $display("FAIL hit1_lookup got=%h exp=%h", out_lookup, e); end
    b = mk_beat(12, 13, 8'h08, 8'h01, 5'd30, 8'h50);
    send_one(b);
    total++; if (hit !== 1'b0 || out_lookup.total_metaShift !== 5'd30) begin bad++; $display("FAIL hit1_masked got hit=%b tms=%0d exp 0/30", hit, out_lookup.total_metaShift); end
  endtask

  task automatic test_priority;
    write_rule(3'd2, rule2);
    write_rule(3'd5, rule5);
    send_one(mk_beat(4, 5, 8'h86, 8'hDD, 5'd2, 8'h60));
    total++; if (hit !== 1'b1 || hit_idx !== 3'd2 || out_lookup.headShift !== 6'd11) begin bad++; $display("FAIL prio_low got hit=%b idx=%0d hs=%0d exp 1/2/11", hit, hit_idx, out_lookup.headShift); end
    send_one(mk_beat(4, 5, 8'h11, 8'h22, 5'd2, 8'h60));
    total++; if (hit !== 1'b1 || hit_idx !== 3'd5 || out_lookup.headShift !== 6'd22) begin bad++; $display("FAIL prio_wild got hit=%b idx=%0d hs=%0d exp 1/5/22", hit, hit_idx, out_lookup.headShift); end
    write_rule(3'd2, '0);
    write_rule(3'd5, '0);
  endtask

  task automatic test_stall;
    layer_info_t q[$];
    layer_info_t beats[5];
    layer_info_t held_info;
    lookup_rst_t held_lk;
    int  sent = 0;
    int  rcvd = 0;
    int  cyc = 0;
    bit  held = 1'b0;
    bit  saw_block = 1'b0;
    for (int i = 0; i < 5; i++) beats[i] = mk_beat(6, 7, 8'hF0, 8'h0F, 5'(i + 1), 8'(16 * i + 3));
    while (rcvd < 5 && cyc < 40) begin
      out_ready = !(cyc >= 2 && cyc <= 4);
      in_valid  = (sent < 5);
      if (sent < 5) in_info = beats[sent];
      @(negedge clk);
      if (held) begin
        total++; if (out_info !== held_info || out_lookup !== held_lk) begin bad++; $display("FAIL stall_hold got info=%h lk=%h exp info=%h lk=%h", out_info, out_lookup, held_info, held_lk); end
      end
      held = 1'b0;
      if (!in_ready) saw_block = 1'b1;
      if (in_valid && in_ready) begin q.push_back(beats[sent]); sent++; end
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin bad++; $display("FAIL stall_dup got extra beat tms=%0d exp none", out_info.total_metaShift); end
        else begin
          if (out_info !== q[0] || out_lookup.total_metaShift !== q[0].total_metaShift || hit !== 1'b0) begin bad++; $display("FAIL stall_order got tms=%0d hit=%b exp tms=%0d hit=0", out_info.total_metaShift, hit, q[0].total_metaShift); end
          void'(q.pop_front());
        end
        rcvd++;
      end else if (out_valid) begin
        held = 1'b1; held_info = out_info; held_lk = out_lookup;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (rcvd != 5 || q.size() != 0) begin bad++; $display("FAIL stall_count got rcvd=%0d left=%0d exp 5/0", rcvd, q.size()); end
    total++; if (saw_block !== 1'b1) begin bad++; $display("FAIL stall_ready got block=%b exp 1", saw_block); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_drain got=%b exp 0", out_valid); end
  endtask

  task automatic test_write_collision;
    in_valid = 1'b1; in_info = mk_beat(0, 1, 8'hAB, 8'hCD, 5'd9, 8'h70);
    tick();
    in_info = mk_beat(0, 1, 8'hAB, 8'hCD, 5'd10, 8'h80);
    wren = 1'b1; rden = 1'b1; addr = 3'd3; wdata = rule3;
    tick();
    in_valid = 1'b0; wren = 1'b0; rden = 1'b0;
    total++; if (out_valid !== 1'b1 || hit !== 1'b0 || out_lookup.total_metaShift !== 5'd9) begin bad++; $display("FAIL wr_old_miss got v=%b hit=%b tms=%0d exp 1/0/9", out_valid, hit, out_lookup.total_metaShift); end
    total++; if (rvalid !== 1'b1 || rdata !== '0) begin bad++; $display("FAIL wr_old_read got rvalid=%b rdata=%h exp 1/0", rvalid, rdata); end
    tick();
    total++; if (out_valid !== 1'b1 || hit !== 1'b1 || hit_idx !== 3'd3 || out_lookup.headShift !== 6'd33) begin bad++; $display("FAIL wr_new_hit got v=%b hit=%b idx=%0d hs=%0d exp 1/1/3/33", out_valid, hit, hit_idx, out_lookup.headShift); end
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL wr_rvalid_pulse got=%b exp 0", rvalid); end
    rden = 1'b1; addr = 3'd3;
    tick();
    rden = 1'b0;
    total++; if (rdata !== rule3) begin bad++; $display("FAIL wr_readback got=%h exp=%h", rdata, rule3); end
  endtask

  task automatic test_reset_inflight;
    bit leak = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_info = mk_beat(12, 13, 8'h08, 8'h00, 5'd30, 8'h11);
    tick();
    in_info = mk_beat(12, 13, 8'h08, 8'h00, 5'd29, 8'h22);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || hit !== 1'b0 || out_lookup !== '0) begin bad++; $display("FAIL rst_async got v=%b hit=%b lk=%h exp 0", out_valid, hit, out_lookup); end
    tick(); tick();
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_valid !== 1'b0) leak = 1'b1;
    end
    total++; if (leak !== 1'b0) begin bad++; $display("FAIL rst_dropped got leak=%b exp 0", leak); end
    rden = 1'b1; addr = 3'd1;
    tick();
    addr = 3'd3;
    total++; if (rdata.typeRule_valid !== 1'b0 || rdata !== '0) begin bad++; $display("FAIL rst_rule1 got=%h exp 0", rdata); end
    tick();
    rden = 1'b0;
    total++; if (rdata !== '0) begin bad++; $display("FAIL rst_rule3 got=%h exp 0", rdata); end
    send_one(mk_beat(12, 13, 8'h08, 8'h00, 5'd30, 8'h33));
    total++; if (out_valid !== 1'b1 || hit !== 1'b0) begin bad++; $display("FAIL rst_miss got v=%b hit=%b exp 1/0", out_valid, hit); end
  endtask

  initial begin
    rule1 = '0;
    rule1.typeRule_valid = 1'b1;
    rule1.typeRule_typeData[0] = 8'h08; rule1.typeRule_typeData[1] = 8'h00;
    rule1.typeRule_typeMask[0] = 8'hFF; rule1.typeRule_typeMask[1] = 8'hFF;
    rule1.typeRule_typeOffset[0] = 5'd20; rule1.typeRule_typeOffset[1] = 5'd21;
    rule1.typeRule_keyOffset_v = 4'hF;
    rule1.typeRule_keyOffset[0] = 6'd1; rule1.typeRule_keyOffset[1] = 6'd2;
    rule1.typeRule_keyOffset[2] = 6'd3; rule1.typeRule_keyOffset[3] = 6'd4;
    rule1.typeRule_keyReplaceOffset[0] = 6'd10; rule1.typeRule_keyReplaceOffset[1] = 6'd11;
    rule1.typeRule_keyReplaceOffset[2] = 6'd12; rule1.typeRule_keyReplaceOffset[3] = 6'd13;
    rule1.typeRule_headShift = 6'd7; rule1.typeRule_metaShift = 5'd3;

    rule2 = '0;
    rule2.typeRule_valid = 1'b1;
    rule2.typeRule_typeData[0] = 8'h86; rule2.typeRule_typeData[1] = 8'hDD;
    rule2.typeRule_typeMask[0] = 8'hFF; rule2.typeRule_typeMask[1] = 8'hFF;
    rule2.typeRule_headShift = 6'd11;

    rule5 = '0;
    rule5.typeRule_valid = 1'b1;
    rule5.typeRule_typeData[0] = 8'h86; rule5.typeRule_typeData[1] = 8'hDD;
    rule5.typeRule_headShift = 6'd22;

    rule3 = '0;
    rule3.typeRule_valid = 1'b1;
    rule3.typeRule_typeData[0] = 8'hAB; rule3.typeRule_typeData[1] = 8'hCD;
    rule3.typeRule_typeMask[0] = 8'hFF; rule3.typeRule_typeMask[1] = 8'hFF;
    rule3.typeRule_headShift = 6'd33;

    test_reset();
    test_miss();
    test_hit_meta();
    test_priority();
    test_stall();
    test_write_collision();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire

// File: doc/parser_type_lookup.md
Name: parser_type_lookup

Overview:
- Match stage of each parser layer; sits directly upstream of the layer's field-extract/shift stage.
- Takes a layer_info_t beat and extracts TYPE_NUM type bytes from its head at the beat's type_offset.
- Matches those bytes against a configurable RULE_NUM-entry type-rule table.
- Emits a lookup_rst_t plus the untouched layer_info_t, 2 cycles later, through a valid/ready pipeline.

Parameters:
- RULE_NUM, 8: number of type-rule entries; must be a power of 2 and ≥2.
- LAYER_ID, 0: layer index, one of LAYER_0..LAYER_3; drives o_layer_id only.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_info_valid  in  1  input beat valid.
- o_info_ready  out  1  input beat accepted when high together with i_info_valid.
- i_info  in  $bits(layer_info_t)  layer info from the previous layer.
- o_info_valid  out  1  output beat valid.
- i_info_ready  in  1  downstream ready.
- o_info  out  $bits(layer_info_t)  i_info passed through unchanged.
- o_lookup  out  $bits(lookup_rst_t)  lookup result.
- o_hit  out  1  a rule matched.
- o_hit_idx  out  $clog2(RULE_NUM)  index of the matching rule.
- o_layer_id  out  2  constant LAYER_ID.
- i_rule_wren  in  1  rule write strobe.
- i_rule_rden  in  1  rule read strobe.
- i_rule_addr  in  $clog2(RULE_NUM)  rule index for write or read.
- i_rule_wdata  in  $bits(type_rule_t)  rule write data.
- o_rule_rvalid  out  1  read data valid.
- o_rule_rdata  out  $bits(type_rule_t)  read data.

Behaviour:
- Reset (async assert, sync deassert use): all rule entries cleared to 0, so every typeRule_valid=0. Both pipe-stage valids 0. o_info_valid, o_hit, o_hit_idx, o_lookup, o_info, o_rule_rvalid, o_rule_rdata all 0. Reset mid-operation drops in-flight beats with no output.
- Pipeline: 2 register stages, S1 (extract) and S2 (match/result).
- Stall control: en = ~S2_valid | i_info_ready. o_info_ready = en. Both stages advance only when en=1.
- Latency: a beat accepted at cycle t appears at cycle t+2 when not stalled. Throughput is 1 beat/cycle.
- While stalled, o_info, o_lookup, o_hit and o_hit_idx hold stable.
- S1 extract: for k in 0..TYPE_NUM-1, type_k = head[TAG_WIDTH+HEAD_WIDTH-1-8*type_offset[k] -: 8]. Byte 0 is the MSB byte of the head data; the tag occupies the low TAG_WIDTH bits.
- S1 also registers the input total_metaShift and the full info.
- S2 match: rule r matches iff typeRule_valid && for all k, ((type_k ^ typeRule_typeData[k]) & typeRule_typeMask[k]) == 0. A mask of 0 is a wildcard.
- Priority: the lowest matching index wins.
- On hit, from winning rule R:
  - typeOffset = R.typeRule_typeOffset; keyOffset_v, keyOffset, headShift, metaShift copied from R.
  - k_replaceOffset = R.typeRule_keyReplaceOffset.
  - {metaShift_carry, total_metaShift} = in.total_metaShift + R.metaShift, computed META_SHIFT_WIDTH+1 wide.
  - For each meta slot j: m_replaceOffset_v[j]=1 iff some valid key i has (in.total_metaShift + i) mod META_CANDI_NUM == j. Then m_replaceOffset[j] = i.
  - m_replaceOffset_carry[j] = 1 iff in.total_metaShift + i ≥ META_CANDI_NUM.
  - All unmapped slots are 0.
- On miss: o_hit=0, o_hit_idx=0. All o_lookup fields 0 except total_metaShift = in.total_metaShift, carry 0. The beat still propagates.
- Config write: the entry is updated at the clock edge following i_rule_wren. An S2 match in the same cycle uses the old contents; the next beat uses the new.
- Config read: o_rule_rvalid/o_rule_rdata are registered, 1 cycle after i_rule_rden. If read and write hit the same address in the same cycle, old data is returned.
- Config ports work independently of the pipeline stall.

Test Plan:
- Reset then beat with any type: o_info_valid at t+2, o_hit=0, total_metaShift passthrough, all other lookup fields 0.
- Rule1 = {valid, data0=0x08, data1=0x00, mask0=0xFF, mask1=0xFF, offset=12,13, headShift=7, metaShift=3}; head bytes 12/13 = 0x08/0x00; in.total_metaShift=30 (META_CANDI_NUM=32) -> o_hit=1, idx=1, headShift=7, total_metaShift=1, metaShift_carry=1.
- Same beat, key valid on 0..3, in.total_metaShift=30 -> m_replaceOffset_v slots 30,31,0,1 set with offsets 0,1,2,3; carry set on slots 0,1 only.
- Rules 2 and 5 both match, rule 5 with mask 0x00 wildcard -> idx=2.
- Hold i_info_ready=0 for 3 cycles with beats queued -> o_info_ready=0 after S2 fills, outputs stable, no beat lost or duplicated, order preserved.
- Write rule 3 in the cycle its matching beat is in S2 -> that beat misses, the next beat hits. Same-cycle read of address 3 returns old data 1 cycle later.
- Assert i_rst_n=0 with 2 beats in flight -> no output, all rules invalid after release.
